fifo_ctrl: RTL
==============

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 150, meaning the number of memory entries (valid range 2..255).
REQ-002 The block SHALL have parameter PTR_W, default 12, meaning the width of the memory pointers.
REQ-003 The block SHALL have parameter AF_LVL, default 140, meaning the occupancy at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LVL, default 10, meaning the occupancy at or below which almost_empty asserts.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  sole clock, all state on posedge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 flush  input  1  discard all contents.
REQ-008 wr_req  input  1  producer requests a write this cycle.
REQ-009 rd_req  input  1  consumer requests a read this cycle.
REQ-010 mem_wr_en  output  1  write enable to the FIFO memory, combinational.
REQ-011 mem_wr_ptr  output  PTR_W  write address to the FIFO memory, registered.
REQ-012 mem_rd_ptr  output  PTR_W  read address to the FIFO memory, registered.
REQ-013 rd_valid  output  1  memory read data is valid this cycle.
REQ-014 full, empty, almost_full, almost_empty  output  1 each  occupancy flags, registered.
REQ-015 count  output  8  current occupancy, 0..DEPTH.
REQ-016 state  output  2  FSM state: 00 EMPTY, 01 ACTIVE, 10 FULL, 11 FLUSH.
REQ-017 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 Write acceptance SHALL be wr_acc = wr_req && !full && state!=FLUSH && !flush; mem_wr_en SHALL equal wr_acc.
REQ-019 Read acceptance SHALL be rd_acc = rd_req && !empty && state!=FLUSH && !flush.
REQ-020 On wr_acc, mem_wr_ptr SHALL advance by 1, wrapping from DEPTH-1 to 0; it SHALL hold otherwise.
REQ-021 On rd_acc, mem_rd_ptr SHALL advance by 1, wrapping from DEPTH-1 to 0; it SHALL hold otherwise.
REQ-022 rd_valid SHALL be asserted exactly one cycle after each rd_acc, giving one-cycle read latency that matches the registered memory read port; it SHALL be low otherwise.
REQ-023 count SHALL increment on wr_acc only, decrement on rd_acc only, and hold when both or neither occur.
REQ-024 Flags SHALL reflect the next count: empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LVL), almost_empty = (count<=AE_LVL).
REQ-025 When empty, a simultaneous write and read SHALL accept only the write: count becomes 1 and rd_valid stays low next cycle.
REQ-026 When full, a simultaneous write and read SHALL accept only the read: count becomes DEPTH-1.
REQ-027 overflow SHALL set when wr_req && full; underflow SHALL set when rd_req && empty (excluding FLUSH). Both SHALL hold until rst.
REQ-028 FSM transitions:
- EMPTY->ACTIVE on wr_acc.
- ACTIVE->FULL when the next count equals DEPTH.
- ACTIVE->EMPTY when the next count equals 0.
- FULL->ACTIVE on rd_acc.
- Any state->FLUSH when flush is high.
- FLUSH->EMPTY on the next cycle.
REQ-029 Entering FLUSH SHALL zero both pointers and count, set empty and almost_empty, clear full and almost_full, and suppress rd_valid; overflow and underflow SHALL be unaffected.
REQ-030 flush held high for N cycles SHALL keep state in FLUSH for N cycles, with exit to EMPTY one cycle after flush deasserts.

Reset
REQ-031 On rst (sampled at posedge), the block SHALL set:
- mem_wr_ptr=0, mem_rd_ptr=0, count=0.
- state=EMPTY, empty=1, almost_empty=1.
- full=0, almost_full=0, rd_valid=0, overflow=0, underflow=0.
- mem_wr_en=0 while rst is high.
REQ-032 rst SHALL take priority over flush and all requests, including mid-operation with the FIFO partially full.

Verification
REQ-033 Reset, then 150 writes with no reads -> count=150, full=1, state=FULL, mem_wr_ptr wrapped to 0, almost_full first asserted after write 140.
REQ-034 From full, issue a 151st wr_req -> mem_wr_en=0, count stays 150, overflow=1 and remains set.
REQ-035 Write 3, then read 3 back-to-back -> rd_valid high on the 3 cycles following each accept, count=0, empty=1, state=EMPTY; a further rd_req sets underflow=1.
REQ-036 Pointer wrap: with count=5 and mem_rd_ptr=148, read 5 -> mem_rd_ptr sequence 149, 0, 1, 2, 3.
REQ-037 With count=0, assert wr_req and rd_req together -> count=1 and no rd_valid; with count=150, assert both -> count=149.
REQ-038 With count=70, pulse flush for 1 cycle alongside wr_req -> no write accepted, state FLUSH then EMPTY, pointers=0, count=0, overflow unchanged.

Source files
------------

// File: rtl/fifo_ctrl.sv
// FIFO controller: pointer, occupancy, flag and state tracking for an external
// single-port-per-side FIFO memory with a one-cycle registered read port.
module fifo_ctrl #(
    parameter int unsigned DEPTH  = 150,
    parameter int unsigned PTR_W  = 12,
    parameter int unsigned AF_LVL = 140,
    parameter int unsigned AE_LVL = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_req,
    input  logic             rd_req,
    output logic             mem_wr_en,
    output logic [PTR_W-1:0] mem_wr_ptr,
    output logic [PTR_W-1:0] mem_rd_ptr,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [7:0]       count,
    output logic [1:0]       state,
    output logic             overflow,
    output logic             underflow
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_FULL   = 2'b10,
        ST_FLUSH  = 2'b11
    } state_e;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [7:0]       CNT_FULL = 8'(DEPTH);
    localparam logic [7:0]       CNT_AF   = 8'(AF_LVL);
    localparam logic [7:0]       CNT_AE   = 8'(AE_LVL);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_acc;
    logic             rd_acc;
    logic             blocked;

    // Request acceptance, next-state and next-value computation
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        blocked = rst || flush || (state_q == ST_FLUSH);
        wr_acc  = wr_req && !full_q  && !blocked;
        rd_acc  = rd_req && !empty_q && !blocked;

        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        rd_valid_d = rd_acc;

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 8'd1;
            2'b01:   count_d = count_q - 8'd1;
            default: count_d = count_q;
        endcase

        // Error flags are sticky; FLUSH activity never counts as misuse
        if (!flush && (state_q != ST_FLUSH)) begin
            if (wr_req && full_q)  ovf_d = 1'b1;
            if (rd_req && empty_q) udf_d = 1'b1;
        end

        unique case (state_q)
            ST_EMPTY:  if (wr_acc) state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (count_d == CNT_FULL)  state_d = ST_FULL;
                else if (count_d == 8'd0) state_d = ST_EMPTY;
            end
            ST_FULL:   if (rd_acc) state_d = ST_ACTIVE;
            ST_FLUSH:  state_d = ST_EMPTY;
            default:   state_d = ST_EMPTY;
        endcase

        if (flush) begin
            state_d  = ST_FLUSH;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 8'd0;
        end

        empty_d = (count_d == 8'd0);
        full_d  = (count_d == CNT_FULL);
        af_d    = (count_d >= CNT_AF);
        ae_d    = (count_d <= CNT_AE);
    end

    // State and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 8'd0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign mem_wr_en    = wr_acc;
    assign mem_wr_ptr   = wr_ptr_q;
    assign mem_rd_ptr   = rd_ptr_q;
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign state        = state_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
